// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and shared-ALU-side signals for alu_arbiter.
// The arbiter connects through the slave modport; whatever models the two
// requesters and the shared ALU connects through the master modport.
interface alu_arbiter_if;
  // Requester 0 / 1 side
  logic       req0;
  logic       req1;
  logic [3:0] op0;
  logic [3:0] op1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;

  // Architectural state visible to both requesters
  logic [7:0] result;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;

  // Shared ALU drive and response
  logic       alu_optype;
  logic [3:0] alu_op;
  logic [7:0] alu_acc;
  logic [7:0] alu_reg;
  logic [7:0] alu_out;
  logic       alu_z;
  logic       alu_c;
  logic       alu_n;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    input  alu_out, alu_z, alu_c, alu_n,
    output gnt0, gnt1, done0, done1,
    output result, flag_z, flag_c, flag_n,
    output alu_optype, alu_op, alu_acc, alu_reg
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    output alu_out, alu_z, alu_c, alu_n,
    input  gnt0, gnt1, done0, done1,
    input  result, flag_z, flag_c, flag_n,
    input  alu_optype, alu_op, alu_acc, alu_reg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// A served request is latched, driven onto the ALU for EXEC_CYCLES cycles,
// and the ALU response is captured into result/flags according to the
// latched opcode.
//
// Handshake: a requester raises reqN with opN/aN/bN stable and keeps them
// stable until it sees doneN; gntN is a one-cycle pulse in the first cycle
// the operation is on the ALU, doneN is a one-cycle pulse once result/flags
// hold the outcome. Operands are latched at grant, so a requester may change
// or drop its inputs after gnt without affecting the operation in flight.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_arbiter_if.slave       bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       sel_q;      // requester currently being served
  logic       last_q;     // requester served most recently
  logic       gnt0_q;
  logic       gnt1_q;
  logic       done0_q;
  logic       done1_q;
  logic [7:0] result_q;
  logic       flag_z_q;
  logic       flag_c_q;
  logic       flag_n_q;
  logic       optype_q;
  logic [3:0] alu_op_q;   // doubles as the latched opcode
  logic [7:0] alu_acc_q;
  logic [7:0] alu_reg_q;

  logic       pick1_d;
  logic       upd_res_d;
  logic       upd_c_d;
  logic       upd_zn_d;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick1_d = 1'b0;
    if (bus.req1 && !bus.req0) begin
      pick1_d = 1'b1;
    end else if (bus.req1 && bus.req0) begin
      pick1_d = ~last_q;
    end
  end

  // Decode which architectural fields the latched opcode is allowed to update.
  always_comb begin
    upd_res_d = 1'b0;
    upd_c_d   = 1'b0;
    upd_zn_d  = 1'b0;
    case (alu_op_q)
      4'b0010, 4'b0011: begin
        upd_res_d = 1'b1;
        upd_c_d   = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001: begin
        upd_res_d = 1'b1;
      end
      4'b1010: begin
        upd_zn_d = 1'b1;
      end
      default: begin
        upd_res_d = 1'b0;
      end
    endcase
  end

  // Main FSM with all outputs registered; gnt/done default low so they pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= 8'd0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      optype_q  <= 1'b1;
      alu_op_q  <= 4'd0;
      alu_acc_q <= 8'd0;
      alu_reg_q <= 8'd0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel_q     <= pick1_d;
            gnt0_q    <= ~pick1_d;
            gnt1_q    <= pick1_d;
            alu_op_q  <= pick1_d ? bus.op1 : bus.op0;
            alu_acc_q <= pick1_d ? bus.a1  : bus.a0;
            alu_reg_q <= pick1_d ? bus.b1  : bus.b0;
            optype_q  <= 1'b0;
            cnt_q     <= CNT_INIT;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == 2'd0) begin
            if (upd_res_d) begin
              result_q <= bus.alu_out;
            end
            if (upd_c_d) begin
              flag_c_q <= bus.alu_c;
            end
            if (upd_zn_d) begin
              flag_z_q <= bus.alu_z;
              flag_n_q <= bus.alu_n;
            end
            optype_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE: begin
          done0_q <= ~sel_q;
          done1_q <= sel_q;
          last_q  <= sel_q;
          state_q <= S_IDLE;
        end
        default: begin
          optype_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.result     = result_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_c     = flag_c_q;
  assign bus.flag_n     = flag_n_q;
  assign bus.alu_optype = optype_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_acc    = alu_acc_q;
  assign bus.alu_reg    = alu_reg_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with EXEC_CYCLES=1 and one with
// EXEC_CYCLES=3, each with its own behavioural shared-ALU model. Expected
// completions ({requester, z, c, n, result}) are queued when a request is
// driven and popped when the matching done pulse appears.
module tb_alu_arbiter;

  localparam int EC_A = 1;
  localparam int EC_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if ifa ();
  alu_arbiter_if ifb ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  alu_arbiter #(.EXEC_CYCLES(EC_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave), .state_o(state_a));
  alu_arbiter #(.EXEC_CYCLES(EC_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave), .state_o(state_b));

  // Shared-ALU model: returns {z, c, n, out}. Unsupported opcodes still
  // produce a non-trivial value so a wrongful capture would show up.
  function automatic logic [10:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] o;
    logic       c;
    c = 1'b0;
    case (op)
      4'b0010: begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; c = w[8]; end
      4'b0011: begin w = {1'b0, a} - {1'b0, b}; o = w[7:0]; c = w[8]; end
      4'b0100: o = a ^ b;
      4'b0101: o = a + 8'd1;
      4'b0110: o = a & b;
      4'b0111: o = a | b;
      4'b1000: o = ~a;
      4'b1001: o = 8'($countones(b));
      4'b1010: o = a - b;
      default: o = a + b;
    endcase
    return {(o == 8'd0), c, o[7], o};
  endfunction

  assign {ifa.alu_z, ifa.alu_c, ifa.alu_n, ifa.alu_out} = alu_model(ifa.alu_op, ifa.alu_acc, ifa.alu_reg);
  assign {ifb.alu_z, ifb.alu_c, ifb.alu_n, ifb.alu_out} = alu_model(ifb.alu_op, ifb.alu_acc, ifb.alu_reg);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [11:0] exp_qa[$];
  logic [11:0] exp_qb[$];
  logic [11:0] ea;
  logic [11:0] eb;

  // Monitor for instance A: exclusivity and completion contents.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.gnt0 || ifa.gnt1) chk("a_gnt_excl", ifa.gnt0 & ifa.gnt1, 0);
      if (ifa.done0 || ifa.done1) begin
        chk("a_done_excl", ifa.done0 & ifa.done1, 0);
        chk("a_done_expected", exp_qa.size() != 0, 1);
        if (exp_qa.size() != 0) begin
          ea = exp_qa.pop_front();
          chk("a_done_id", ifa.done1, ea[11]);
          chk("a_result", ifa.result, ea[7:0]);
          chk("a_flags_zcn", {ifa.flag_z, ifa.flag_c, ifa.flag_n}, ea[10:8]);
        end
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifb.gnt0 || ifb.gnt1) chk("b_gnt_excl", ifb.gnt0 & ifb.gnt1, 0);
      if (ifb.done0 || ifb.done1) begin
        chk("b_done_excl", ifb.done0 & ifb.done1, 0);
        chk("b_done_expected", exp_qb.size() != 0, 1);
        if (exp_qb.size() != 0) begin
          eb = exp_qb.pop_front();
          chk("b_done_id", ifb.done1, eb[11]);
          chk("b_result", ifb.result, eb[7:0]);
          chk("b_flags_zcn", {ifb.flag_z, ifb.flag_c, ifb.flag_n}, eb[10:8]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic get_gnt(input int inst, input bit id);
    if (inst == 0) return id ? ifa.gnt1 : ifa.gnt0;
    return id ? ifb.gnt1 : ifb.gnt0;
  endfunction

  function automatic logic get_done(input int inst, input bit id);
    if (inst == 0) return id ? ifa.done1 : ifa.done0;
    return id ? ifb.done1 : ifb.done0;
  endfunction

  function automatic logic get_optype(input int inst);
    return (inst == 0) ? ifa.alu_optype : ifb.alu_optype;
  endfunction

  task automatic set_req(input int inst, input bit id, input logic v,
                         input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (inst == 0) begin
      if (id) begin ifa.req1 = v; ifa.op1 = op; ifa.a1 = a; ifa.b1 = b; end
      else    begin ifa.req0 = v; ifa.op0 = op; ifa.a0 = a; ifa.b0 = b; end
    end else begin
      if (id) begin ifb.req1 = v; ifb.op1 = op; ifb.a1 = a; ifb.b1 = b; end
      else    begin ifb.req0 = v; ifb.op0 = op; ifb.a0 = a; ifb.b0 = b; end
    end
  endtask

  // Raise a request, wait for its grant and done, check latency, grant wait
  // (when exp_wait > 0) and the number of cycles the ALU was driven.
  task automatic do_op(input int inst, input bit id, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b, input int exp_wait,
                       input bit push, input logic [11:0] entry);
    int wait_c;
    int lat;
    int lows;
    int ec;
    ec = (inst == 0) ? EC_A : EC_B;
    if (push) begin
      if (inst == 0) exp_qa.push_back(entry);
      else           exp_qb.push_back(entry);
    end
    @(negedge clk);
    set_req(inst, id, 1'b1, op, a, b);
    wait_c = 0;
    while (!get_gnt(inst, id) && wait_c < 40) begin
      @(negedge clk);
      wait_c++;
    end
    if (!get_gnt(inst, id)) begin
      chk($sformatf("i%0d_r%0d_gnt_timeout", inst, id), wait_c, 0);
      set_req(inst, id, 1'b0, op, a, b);
      return;
    end
    if (exp_wait > 0) chk($sformatf("i%0d_r%0d_gnt_wait", inst, id), wait_c, exp_wait);
    lat  = 0;
    lows = (get_optype(inst) == 1'b0) ? 1 : 0;
    while (!get_done(inst, id) && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!get_done(inst, id) && get_optype(inst) == 1'b0) lows++;
    end
    chk($sformatf("i%0d_r%0d_done_latency", inst, id), lat, ec + 1);
    chk($sformatf("i%0d_r%0d_exec_cycles", inst, id), lows, ec);
    set_req(inst, id, 1'b0, op, a, b);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wd;
    ifa.req0 = 0; ifa.req1 = 0; ifa.op0 = 0; ifa.op1 = 0;
    ifa.a0 = 0; ifa.b0 = 0; ifa.a1 = 0; ifa.b1 = 0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.op0 = 0; ifb.op1 = 0;
    ifb.a0 = 0; ifb.b0 = 0; ifb.a1 = 0; ifb.b1 = 0;

    apply_reset();
    // Reset state
    chk("rst_state", state_a, 0);
    chk("rst_gnt", {ifa.gnt0, ifa.gnt1}, 0);
    chk("rst_done", {ifa.done0, ifa.done1}, 0);
    chk("rst_result", ifa.result, 0);
    chk("rst_flags", {ifa.flag_z, ifa.flag_c, ifa.flag_n}, 0);
    chk("rst_optype", ifa.alu_optype, 1);
    chk("rst_alu_drive", {ifa.alu_op, ifa.alu_acc, ifa.alu_reg}, 0);

    // ADD with carry out: 200+100 -> 44, c=1, z/n untouched
    do_op(0, 0, 4'b0010, 8'd200, 8'd100, 1, 1, {1'b0, 3'b010, 8'd44});

    // Simultaneous requests after reset: requester 0 first, then 1
    apply_reset();
    exp_qa.push_back({1'b0, 3'b000, 8'h30});
    exp_qa.push_back({1'b1, 3'b000, 8'h3F});
    fork
      do_op(0, 0, 4'b0110, 8'hF0, 8'h3C, 1, 0, 12'd0);
      do_op(0, 1, 4'b0111, 8'h0F, 8'h30, 0, 0, 12'd0);
    join

    // Set result to 0x30, then compares update only z/n
    do_op(0, 0, 4'b0110, 8'hF0, 8'h3C, 1, 1, {1'b0, 3'b000, 8'h30});
    do_op(0, 1, 4'b1010, 8'd5,  8'd9,  1, 1, {1'b1, 3'b001, 8'h30});
    do_op(0, 0, 4'b1010, 8'd9,  8'd9,  1, 1, {1'b0, 3'b100, 8'h30});
    // Unsupported opcodes: granted and completed, nothing changes
    do_op(0, 1, 4'b1111, 8'd1,  8'd1,  1, 1, {1'b1, 3'b100, 8'h30});
    do_op(0, 0, 4'b0000, 8'd3,  8'd4,  1, 1, {1'b0, 3'b100, 8'h30});
    // SUB with borrow updates result and c only
    do_op(0, 1, 4'b0011, 8'd3,  8'd10, 1, 1, {1'b1, 3'b110, 8'hF9});
    // XOR updates result only (model offers c=0, n=1)
    do_op(0, 0, 4'b0100, 8'h55, 8'hFF, 1, 1, {1'b0, 3'b110, 8'hAA});
    // Random-operand ANDs/ORs
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 2 == 0) do_op(0, 1, 4'b0110, ra, rb, 1, 1, {1'b1, 3'b110, ra & rb});
      else            do_op(0, 0, 4'b0111, ra, rb, 1, 1, {1'b0, 3'b110, ra | rb});
    end

    // Reset asserted mid-EXEC
    @(negedge clk);
    set_req(0, 0, 1'b1, 4'b0010, 8'd1, 8'd1);
    @(posedge clk); #1;
    chk("rm_gnt0", ifa.gnt0, 1);
    chk("rm_state_exec", state_a, 1);
    reset = 1'b1;
    #1;
    chk("rm_gnt0_cleared", ifa.gnt0, 0);
    chk("rm_state_idle", state_a, 0);
    chk("rm_result", ifa.result, 0);
    chk("rm_flags", {ifa.flag_z, ifa.flag_c, ifa.flag_n}, 0);
    chk("rm_optype", ifa.alu_optype, 1);
    chk("rm_alu_drive", {ifa.alu_op, ifa.alu_acc, ifa.alu_reg}, 0);
    @(negedge clk);
    chk("rm_no_done_1", {ifa.done0, ifa.done1}, 0);
    @(negedge clk);
    chk("rm_no_done_2", {ifa.done0, ifa.done1}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rm_regrant", ifa.gnt0, 1);
    exp_qa.push_back({1'b0, 3'b000, 8'd2});
    wd = 0;
    while (!ifa.done0 && wd < 10) begin
      @(negedge clk);
      wd++;
    end
    chk("rm_done_seen", ifa.done0, 1);
    set_req(0, 0, 1'b0, 4'b0010, 8'd1, 8'd1);

    // EXEC_CYCLES=3: popcount of 0xFF -> 8, done 4 cycles after gnt
    do_op(1, 1, 4'b1001, 8'd0, 8'hFF, 1, 1, {1'b1, 3'b000, 8'd8});
    do_op(1, 0, 4'b0010, 8'd250, 8'd10, 1, 1, {1'b0, 3'b010, 8'd4});

    repeat (3) @(negedge clk);
    chk("a_queue_drained", exp_qa.size(), 0);
    chk("b_queue_drained", exp_qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
